// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
//   A write strobe pushes data_in into a power-of-two FIFO. A framing FSM
//   (IDLE/START/DATA/PARITY/STOP) drains the FIFO one frame at a time. The
//   frame is a start bit, data_bits data bits sent LSB first, an optional
//   parity bit and stop_bits stop bits. Each bit lasts freq_in/freq_out
//   clock cycles. When the FIFO is not empty, frames follow each other
//   with no idle cycle between them.
// Parameters:
//   freq_in, freq_out  clock and baud rate; the bit period is their integer quotient (>= 2)
//   data_bits          5..9
//   parity             0 none, 1 odd, 2 even
//   stop_bits          1 or 2
//   fifo_depth         power of two, >= 2
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   data_in, data_coming    write word and write strobe (sampled every edge)
//   clear_overflow          clears the sticky overflow flag
//   uart_out                registered serial line, idle high
//   busy                    FSM not in IDLE
//   empty, full, fifo_count FIFO status
//   overflow                sticky: a write arrived while full and was dropped
module uart_tx_fifo #(
  parameter int freq_in    = 50_000_000,
  parameter int freq_out   = 57_600,
  parameter int data_bits  = 8,
  parameter int parity     = 0,
  parameter int stop_bits  = 1,
  parameter int fifo_depth = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [data_bits-1:0]              data_in,
  input  logic                              data_coming,
  input  logic                              clear_overflow,
  output logic                              uart_out,
  output logic                              busy,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(fifo_depth+1)-1:0]   fifo_count,
  output logic                              overflow
);

  localparam int divisor = freq_in / freq_out;
  localparam int cnt_w   = $clog2(divisor);
  localparam int ptr_w   = $clog2(fifo_depth);
  localparam int fc_w    = $clog2(fifo_depth + 1);
  localparam int idx_w   = 4;  // covers data bit index 0..8 and stop index 0..1
  localparam logic [cnt_w-1:0] reload = cnt_w'(divisor - 1);

  // ---------------------------------------------------------------- FIFO
  logic [data_bits-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]     wr_ptr, rd_ptr;
  logic [data_bits-1:0] head;
  logic                 push, pop;

  // full is taken from the registered count. A pop on the same edge
  // therefore never frees a slot for the write that arrives with it.
  assign push  = data_coming && !full;
  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == fc_w'(fifo_depth));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage is not reset; the pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (reset_n && push) mem[wr_ptr] <= data_in;
  end

  // A dropped write sets the flag. Setting wins over clearing on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n)                 overflow <= 1'b0;
    else if (data_coming && full) overflow <= 1'b1;
    else if (clear_overflow)      overflow <= 1'b0;
  end

  // ---------------------------------------------------------------- framer
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [cnt_w-1:0]     bit_cnt, bit_cnt_next;
  logic [idx_w-1:0]     bit_idx, bit_idx_next;
  logic [data_bits-1:0] shreg, shreg_next;
  logic                 par_q, par_next, par_head;
  logic                 uart_next;
  logic                 bit_end, last_data, last_stop;

  assign bit_end   = (bit_cnt == '0);
  assign last_data = (bit_idx == idx_w'(data_bits - 1));
  assign last_stop = (bit_idx == idx_w'(stop_bits - 1));
  // The parity bit is computed when the word is loaded, before any shifting.
  assign par_head  = (parity == 1) ? ~^head : ^head;
  assign busy      = (state != IDLE);

  // State register. It also holds the framing datapath.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      uart_out <= 1'b1;
      bit_cnt  <= reload;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
    end else begin
      state    <= state_next;
      uart_out <= uart_next;
      bit_cnt  <= bit_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      par_q    <= par_next;
    end
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && last_data) state_next = (parity != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end && last_stop) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. uart_next is the line level for the bit that the next state
  // drives. The line is registered, so it never glitches.
  always_comb begin
    pop          = 1'b0;
    uart_next    = uart_out;
    bit_cnt_next = bit_end ? reload : bit_cnt - 1'b1;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    par_next     = par_q;
    case (state)
      IDLE: begin
        bit_cnt_next = reload;
        if (!empty) begin
          pop        = 1'b1;
          uart_next  = 1'b0;
          shreg_next = head;
          par_next   = par_head;
        end
      end
      START: begin
        if (bit_end) begin
          uart_next    = shreg[0];
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            bit_idx_next = '0;
            uart_next    = (parity != 0) ? par_q : 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            uart_next    = shreg[1];
            shreg_next   = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          uart_next    = 1'b1;
          bit_idx_next = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            uart_next = 1'b1;
            // Back-to-back frame: the next start bit begins on this edge.
            if (!empty) begin
              pop        = 1'b1;
              uart_next  = 1'b0;
              shreg_next = head;
              par_next   = par_head;
            end
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        uart_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       clr;
  logic [3:0] wr, uo, bz, em, fu, ov;
  logic [4:0] cnt0, cnt2, cnt3;
  logic [2:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // unit 0: 8N1 depth 16; unit 1: 8N1 depth 4; unit 2: 7E2; unit 3: 7O2. All use a bit period of 8.
  uart_tx_fifo #(.freq_in(8), .freq_out(1), .data_bits(8), .parity(0), .stop_bits(1), .fifo_depth(16)) u0 (
    .clock(clk), .reset_n(rst_n), .data_in(din), .data_coming(wr[0]), .clear_overflow(clr),
    .uart_out(uo[0]), .busy(bz[0]), .empty(em[0]), .full(fu[0]), .fifo_count(cnt0), .overflow(ov[0]));
  uart_tx_fifo #(.freq_in(8), .freq_out(1), .data_bits(8), .parity(0), .stop_bits(1), .fifo_depth(4)) u1 (
    .clock(clk), .reset_n(rst_n), .data_in(din), .data_coming(wr[1]), .clear_overflow(clr),
    .uart_out(uo[1]), .busy(bz[1]), .empty(em[1]), .full(fu[1]), .fifo_count(cnt1), .overflow(ov[1]));
  uart_tx_fifo #(.freq_in(8), .freq_out(1), .data_bits(7), .parity(2), .stop_bits(2), .fifo_depth(16)) u2 (
    .clock(clk), .reset_n(rst_n), .data_in(din[6:0]), .data_coming(wr[2]), .clear_overflow(clr),
    .uart_out(uo[2]), .busy(bz[2]), .empty(em[2]), .full(fu[2]), .fifo_count(cnt2), .overflow(ov[2]));
  uart_tx_fifo #(.freq_in(8), .freq_out(1), .data_bits(7), .parity(1), .stop_bits(2), .fifo_depth(16)) u3 (
    .clock(clk), .reset_n(rst_n), .data_in(din[6:0]), .data_coming(wr[3]), .clear_overflow(clr),
    .uart_out(uo[3]), .busy(bz[3]), .empty(em[3]), .full(fu[3]), .fifo_count(cnt3), .overflow(ov[3]));

  // slots: the line level for each bit period in time order, read from the MSB down.
  typedef struct packed {
    logic [1:0]  unit;
    logic [7:0]  data;
    logic [3:0]  nslots;
    logic [15:0] slots;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Call this between the write edge and the next edge. It checks the line
  // for every cycle of n slots. The line must be busy throughout and idle
  // one edge later. empty must read 1 from cycle empty_at on (and 0 just before).
  task automatic check_stream(input int unit, input logic [63:0] pat, input int n,
                              input int empty_at, input string name);
    for (int k = 0; k < n * 8; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s uart k=%0d", name, k), uo[unit], pat[63 - k / 8]);
      chk($sformatf("%s busy k=%0d", name, k), bz[unit], 1);
      if (empty_at > 0 && k == empty_at - 1) chk($sformatf("%s empty k=%0d", name, k), em[unit], 0);
      if (k == empty_at) chk($sformatf("%s empty k=%0d", name, k), em[unit], 1);
    end
    @(posedge clk); @(negedge clk);
    chk({name, " busy end"}, bz[unit], 0);
    chk({name, " uart end"}, uo[unit], 1);
  endtask

  task automatic run_frame(input int unit, input logic [7:0] data, input int n,
                           input logic [15:0] slots, input string name);
    @(negedge clk); din = data; wr[unit] = 1'b1;
    @(negedge clk); wr[unit] = 1'b0;
    chk({name, " busy pre"}, bz[unit], 0);
    chk({name, " uart pre"}, uo[unit], 1);
    chk({name, " empty pre"}, em[unit], 0);
    check_stream(unit, {slots, 48'b0}, n, 0, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 8'hA5, 4'd10, {10'b0101001011, 6'b0}};
    tbl[1] = '{2'd0, 8'h00, 4'd10, {10'b0000000001, 6'b0}};
    tbl[2] = '{2'd0, 8'hFF, 4'd10, {10'b0111111111, 6'b0}};
    tbl[3] = '{2'd2, 8'h03, 4'd11, {11'b01100000011, 5'b0}};
    tbl[4] = '{2'd3, 8'h03, 4'd11, {11'b01100000111, 5'b0}};
    tbl[5] = '{2'd2, 8'h7F, 4'd11, {11'b01111111111, 5'b0}};
    tbl[6] = '{2'd3, 8'h7F, 4'd11, {11'b01111111011, 5'b0}};
    tbl[7] = '{2'd2, 8'h55, 4'd11, {11'b01010101011, 5'b0}};
    tbl[8] = '{2'd1, 8'hC3, 4'd10, {10'b0110000111, 6'b0}};

    rst_n = 1'b0; din = '0; wr = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset uart", uo, 4'hF);
    chk("reset busy", bz, 0);
    chk("reset empty", em, 4'hF);
    chk("reset full", fu, 0);
    chk("reset overflow", ov, 0);
    chk("reset count0", cnt0, 0);
    chk("reset count1", cnt1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_frame(tbl[i].unit, tbl[i].data, tbl[i].nslots, tbl[i].slots, $sformatf("vec%0d", i));

    // Three writes on consecutive cycles produce 240 contiguous framing cycles.
    @(negedge clk); din = 8'h00; wr[0] = 1'b1;
    @(negedge clk); din = 8'hFF;
    fork
      begin
        @(negedge clk); din = 8'h55;
        @(negedge clk); wr[0] = 1'b0;
        chk("burst count", cnt0, 2);
      end
      check_stream(0, {10'b0000000001, 10'b0111111111, 10'b0101010101, 34'b0}, 30, 160, "burst");
    join

    // Depth 4, six writes on consecutive cycles: the sixth write is dropped.
    @(negedge clk); din = 8'h11; wr[1] = 1'b1;
    @(negedge clk);
    chk("d4 count n1", cnt1, 1);
    chk("d4 busy n1", bz[1], 0);
    fork
      begin
        din = 8'h22;
        @(negedge clk); din = 8'h33;
        chk("d4 popped count", cnt1, 1);
        @(negedge clk); din = 8'h44;
        @(negedge clk); din = 8'h55;
        @(negedge clk); din = 8'h66;
        chk("d4 full n5", fu[1], 1);
        chk("d4 count n5", cnt1, 4);
        chk("d4 ovf n5", ov[1], 0);
        @(negedge clk); wr[1] = 1'b0;
        chk("d4 ovf n6", ov[1], 1);
        chk("d4 count n6", cnt1, 4);
      end
      check_stream(1, {10'b0100010001, 10'b0010001001, 10'b0110011001,
                       10'b0001000101, 10'b0101010101, 14'b0}, 50, 320, "d4");
    join
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk($sformatf("d4 idle uart k=%0d", k), uo[1], 1);
    end
    chk("d4 idle empty", em[1], 1);

    // Overflow is still set. Fill the FIFO, then send clear together with a dropped write.
    @(negedge clk); din = 8'h01; wr[1] = 1'b1;
    @(negedge clk); din = 8'h02;
    @(negedge clk); din = 8'h03;
    @(negedge clk); din = 8'h04;
    @(negedge clk); din = 8'h05;
    @(negedge clk); din = 8'h06; clr = 1'b1;
    chk("ovf full", fu[1], 1);
    chk("ovf still set", ov[1], 1);
    @(negedge clk); wr[1] = 1'b0;
    chk("ovf set beats clear", ov[1], 1);
    @(negedge clk); clr = 1'b0;
    chk("ovf cleared", ov[1], 0);

    // Reset during data bit 3 of 0xA1 while two more words are queued.
    @(negedge clk); din = 8'hA1; wr[0] = 1'b1;
    @(negedge clk); din = 8'hB2;
    @(negedge clk); din = 8'hC3;
    @(negedge clk); wr[0] = 1'b0;
    chk("rst queued count", cnt0, 2);
    repeat (34) @(negedge clk);
    chk("rst pre bit3", uo[0], 0);
    chk("rst pre busy", bz[0], 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst uart", uo[0], 1);
    chk("rst busy", bz[0], 0);
    chk("rst empty", em[0], 1);
    chk("rst count", cnt0, 0);
    chk("rst overflow", ov[0], 0);
    chk("rst u1 busy", bz[1], 0);
    chk("rst u1 count", cnt1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst idle", uo[0], 1);
    run_frame(0, 8'h3C, 10, {10'b0001111001, 6'b0}, "post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter that replaces the bare serialiser between the CPU output port and the board UART_TX pin. A CPU write strobe pushes a word into a FIFO, and a framing state machine drains it with configurable data width, parity and stop bits. Full, empty, level and sticky overflow status let the top level show dropped output on the HEX displays instead of silently losing bytes.

## Interface
- freq_in, 50_000_000: input clock frequency, Hz
- freq_out, 57_600: baud rate; bit period divisor = freq_in / freq_out, integer floor, must be ≥ 2
- data_bits, 8: data bits per frame, 5..9
- parity, 0: 0 none, 1 odd, 2 even
- stop_bits, 1: 1 or 2
- fifo_depth, 16: FIFO entries, power of two, ≥ 2
- clock  in  1  single clock; all logic rising-edge
- reset_n  in  1  reset, synchronous, active-low
- data_in  in  data_bits  word to transmit
- data_coming  in  1  write strobe; data_in sampled on every edge where high
- clear_overflow  in  1  clears sticky overflow
- uart_out  out  1  serial line, idle high, registered
- busy  out  1  FSM not IDLE
- empty  out  1  FIFO holds 0 words
- full  out  1  FIFO holds fifo_depth words
- fifo_count  out  $clog2(fifo_depth+1)  FIFO occupancy
- overflow  out  1  sticky: a write was dropped

## Operation
- Reset (reset_n low at an edge): uart_out=1, busy=0, empty=1, full=0, fifo_count=0, overflow=0; FIFO flushed; FSM to IDLE. An in-flight frame is aborted and the line is high after that edge.
- Write: accepted iff data_coming=1 and full=0 at the sampling edge. A pop in the same cycle does not free a slot for that write. A rejected write sets overflow.
- overflow: set has priority over clear_overflow in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO is non-empty at an edge, pop the head into the shift register, drive uart_out=0 and go to START.
  - START → DATA → PARITY (skipped when parity=0) → STOP.
  - Each bit lasts exactly divisor cycles, timed by a bit counter that reloads on each bit boundary.
- DATA: LSB first, data_bits bits.
- PARITY: the bit that makes the count of ones over data plus parity odd (parity=1) or even (parity=2).
- STOP: uart_out=1 for stop_bits × divisor cycles. On the last STOP cycle's edge:
  - FIFO non-empty: pop and go directly to START, giving back-to-back frames with no idle cycle.
  - FIFO empty: go to IDLE.
- Push and pop on the same edge: fifo_count unchanged; read/write pointers wrap modulo fifo_depth.
- The FIFO never pops when empty. There is no write-to-output bypass.

## Timing
- Latency: a write accepted at edge N into an idle, empty block makes uart_out=0 and busy=1 after edge N+1. empty reads 0 for exactly one cycle.
- Frame length: (1 + data_bits + (parity≠0) + stop_bits) × divisor cycles.
- busy falls on the edge that ends the last stop bit, only if the FIFO is empty.
- Status outputs are registered; they reflect the pointer state after each edge.
- uart_out is glitch-free: a register output with no combinational path from the inputs.

## Test plan
- 8N1, freq_in=8, freq_out=1 (divisor 8), write 0xA5 → start 0 for 8 cycles, then 1,0,1,0,0,1,0,1 at 8 cycles each, then stop 1 for 8 cycles. busy is high for exactly 80 cycles, starting one cycle after the write.
- Same configuration, write 0x00, 0xFF, 0x55 on three consecutive cycles → 240 contiguous cycles of framing with no idle gap between frames. empty=1 after the third pop; busy=0 after cycle 240.
- fifo_depth=4, six writes on consecutive cycles from idle:
  - first word pops one cycle after its write;
  - full=1 and fifo_count=4 after the fifth write;
  - sixth write dropped, overflow=1;
  - five frames transmitted, sixth word never appears.
- data_bits=7, parity=2, stop_bits=2, write 0x03 → data bits 1,1,0,0,0,0,0, parity 0, stop high for 16 cycles. With parity=1 the parity bit is 1.
- Assert reset_n low during data bit 3 with 2 words queued → after that edge uart_out=1, busy=0, empty=1, fifo_count=0, overflow=0. After reset_n is released, a write of 0x3C transmits correctly.
- Set overflow, then assert clear_overflow on the same cycle as a write to a full FIFO → overflow stays 1. clear_overflow alone on the next cycle → overflow=0.
